// File: rtl/alu_md_unit_if.sv
// EX-stage ALU / multiply-divide bundle: the pipeline drives the master side, alu_md_unit the slave side.
interface alu_md_unit_if #(
    parameter int WIDTH = 32
);
    logic             issue;
    logic             flush;
    logic [2:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output issue, flush, alu_op, funct, a, b,
        input  result, zero, illegal, busy, stall, hi, lo
    );

    modport slave (
        input  issue, flush, alu_op, funct, a, b,
        output result, zero, illegal, busy, stall, hi, lo
    );
endinterface

// File: rtl/alu_md_unit.sv
// ALU decode/execute (combinational) plus iterative mult/div engine with HI/LO; mult/div take WIDTH+1 cycles.
// HI/LO-touching instructions raise stall while the engine is busy; plain ALU ops never stall.
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    alu_md_unit_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opb, r_a_raw;
    logic               r_sign_a, r_sign_b, r_signed, r_div, r_bzero;

    logic [WIDTH-1:0]   w_res;
    logic               w_bad, w_is_md, w_is_hilo, w_is_mthi, w_is_mtlo, w_md_signed, w_md_div;
    logic               w_stall, w_start, w_wr_hi, w_wr_lo, w_busy;
    logic               w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_msum, w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_dsub;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    always_comb begin
        w_res       = '0;
        w_bad       = 1'b0;
        w_is_md     = 1'b0;
        w_is_hilo   = 1'b0;
        w_is_mthi   = 1'b0;
        w_is_mtlo   = 1'b0;
        w_md_signed = 1'b0;
        w_md_div    = 1'b0;
        case (bus.alu_op)
            3'b000: w_res = bus.a + bus.b;
            3'b001: w_res = bus.a - bus.b;
            3'b011: w_res = bus.a & bus.b;
            3'b100: w_res = bus.a | bus.b;
            3'b111: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            3'b010: begin
                case (bus.funct)
                    6'b100000: w_res = bus.a + bus.b;
                    6'b100010: w_res = bus.a - bus.b;
                    6'b100100: w_res = bus.a & bus.b;
                    6'b100101: w_res = bus.a | bus.b;
                    6'b100110: w_res = bus.a ^ bus.b;
                    6'b100111: w_res = ~(bus.a | bus.b);
                    6'b101010: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                    6'b101011: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                    6'b010000: begin w_res = r_hi; w_is_hilo = 1'b1; end
                    6'b010010: begin w_res = r_lo; w_is_hilo = 1'b1; end
                    6'b010001: begin w_is_mthi = 1'b1; w_is_hilo = 1'b1; end
                    6'b010011: begin w_is_mtlo = 1'b1; w_is_hilo = 1'b1; end
                    6'b011000: begin w_is_md = 1'b1; w_is_hilo = 1'b1; w_md_signed = 1'b1; end
                    6'b011001: begin w_is_md = 1'b1; w_is_hilo = 1'b1; end
                    6'b011010: begin w_is_md = 1'b1; w_is_hilo = 1'b1; w_md_signed = 1'b1; w_md_div = 1'b1; end
                    6'b011011: begin w_is_md = 1'b1; w_is_hilo = 1'b1; w_md_div = 1'b1; end
                    default:   w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_busy  = (r_state != S_IDLE);
    assign w_stall = bus.issue & w_busy & w_is_hilo;
    assign w_start = bus.issue & w_is_md   & ~w_stall & ~bus.flush;
    assign w_wr_hi = bus.issue & w_is_mthi & ~w_stall & ~bus.flush;
    assign w_wr_lo = bus.issue & w_is_mtlo & ~w_stall & ~bus.flush;

    // The engine works on magnitudes; signs are reapplied in FIX.
    assign w_neg_a = w_md_signed & bus.a[WIDTH-1];
    assign w_neg_b = w_md_signed & bus.b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -bus.a : bus.a;
    assign w_mag_b = w_neg_b ? -bus.b : bus.b;

    assign w_msum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_dsub  = w_shift[WIDTH-1:0] - r_opb;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_signed & (r_sign_a ^ r_sign_b)) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_signed & (r_sign_a ^ r_sign_b)) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = (r_signed & r_sign_a) ? -r_acc_hi : r_acc_hi;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_nxt = S_RUN;
                S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_a_raw  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_signed <= 1'b0;
            r_div    <= 1'b0;
            r_bzero  <= 1'b0;
        end else begin
            if (w_start) begin
                r_acc_hi <= '0;
                r_acc_lo <= w_mag_a;
                r_opb    <= w_mag_b;
                r_a_raw  <= bus.a;
                r_sign_a <= bus.a[WIDTH-1];
                r_sign_b <= bus.b[WIDTH-1];
                r_signed <= w_md_signed;
                r_div    <= w_md_div;
                r_bzero  <= (bus.b == '0);
                r_cnt    <= CNT_W'(WIDTH-1);
            end else if (r_state == S_RUN && !bus.flush) begin
                if (r_div) begin
                    r_acc_hi <= w_ge ? w_dsub : w_shift[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                end else begin
                    r_acc_hi <= w_msum[WIDTH:1];
                    r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
                end
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end

            if (r_state == S_FIX && !bus.flush) begin
                if (!r_div) begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end else if (r_bzero) begin
                    r_hi <= r_a_raw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end else begin
                if (w_wr_hi) r_hi <= bus.a;
                if (w_wr_lo) r_lo <= bus.a;
            end
        end
    end

    assign bus.result  = w_res;
    assign bus.zero    = (w_res == '0);
    assign bus.illegal = bus.issue & w_bad;
    assign bus.busy    = w_busy;
    assign bus.stall   = w_stall;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule
